// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package mc_ctrl_fsm_pkg;

    // Immediate format selector consumed by the immediate generator.
    typedef enum logic [2:0] {
        INST_TYPE_R = 3'd0,
        INST_TYPE_I = 3'd1,
        INST_TYPE_S = 3'd2,
        INST_TYPE_B = 3'd3,
        INST_TYPE_U = 3'd4,
        INST_TYPE_J = 3'd5
    } cs_inst_type;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        ST_TRAP   = 3'd6
`endif
    } ctrl_state_t;

    // Instruction classes that determine the sequencing path.
    typedef enum logic [3:0] {
        CLASS_LUI     = 4'd0,
        CLASS_AUIPC   = 4'd1,
        CLASS_JAL     = 4'd2,
        CLASS_JALR    = 4'd3,
        CLASS_BRANCH  = 4'd4,
        CLASS_LOAD    = 4'd5,
        CLASS_STORE   = 4'd6,
        CLASS_OP_IMM  = 4'd7,
        CLASS_OP      = 4'd8,
        CLASS_FENCE   = 4'd9,
        CLASS_ILLEGAL = 4'd10
    } inst_class_t;

    // Major opcodes (full 7 bits, so inst[1:0] must be 2'b11 to match).
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // Next-PC source.
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_ALU    = 2'd2;

    // Register file write-back source.
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    // ALU operand selects.
    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;
    localparam logic       ALU_B_RS2  = 1'b0;
    localparam logic       ALU_B_IMM  = 1'b1;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational instruction decoder: classifies the instruction, picks the
// immediate format and forms the ALU operation code.
module ctrl_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [31:0] inst,
    output inst_class_t inst_class,
    output cs_inst_type inst_type,
    output logic [3:0]  alu_op,
    output logic        illegal
);

    logic [2:0] funct3;
    logic       unused_bits;

    assign funct3      = inst[14:12];
    // Only opcode, funct3 and bit 30 matter to control.
    assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

    // Opcode -> class and immediate format; anything unmatched is illegal.
    always_comb begin
        inst_class = CLASS_ILLEGAL;
        inst_type  = INST_TYPE_I;
        case (inst[6:0])
            OPC_LUI:    begin inst_class = CLASS_LUI;    inst_type = INST_TYPE_U; end
            OPC_AUIPC:  begin inst_class = CLASS_AUIPC;  inst_type = INST_TYPE_U; end
            OPC_JAL:    begin inst_class = CLASS_JAL;    inst_type = INST_TYPE_J; end
            OPC_JALR:   begin inst_class = CLASS_JALR;   inst_type = INST_TYPE_I; end
            OPC_BRANCH: begin inst_class = CLASS_BRANCH; inst_type = INST_TYPE_B; end
            OPC_LOAD:   begin inst_class = CLASS_LOAD;   inst_type = INST_TYPE_I; end
            OPC_STORE:  begin inst_class = CLASS_STORE;  inst_type = INST_TYPE_S; end
            OPC_OP_IMM: begin inst_class = CLASS_OP_IMM; inst_type = INST_TYPE_I; end
            OPC_OP:     begin inst_class = CLASS_OP;     inst_type = INST_TYPE_R; end
            OPC_FENCE:  begin inst_class = CLASS_FENCE;  inst_type = INST_TYPE_I; end
            default:    begin inst_class = CLASS_ILLEGAL; inst_type = INST_TYPE_I; end
        endcase
    end

    // ALU op: bit 30 only qualifies register ops and immediate shifts.
    always_comb begin
        alu_op = 4'b0000;
        if (inst_class == CLASS_OP) begin
            alu_op = {inst[30], funct3};
        end else if (inst_class == CLASS_OP_IMM) begin
            if (funct3[1:0] == 2'b01) begin
                alu_op = {inst[30], funct3};
            end else begin
                alu_op = {1'b0, funct3};
            end
        end
    end

    assign illegal = (inst_class == CLASS_ILLEGAL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over a
// single shared memory port. Optional macro CTRL_ILLEGAL_TRAP_EN sends
// illegal instructions to a sticky TRAP state with a trap_o output.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter bit RST_PC_WE = 1'b0
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic        mem_ready_i,
    input  logic        br_taken_i,
    output cs_inst_type inst_type_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_src_o,
    output logic [1:0]  alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic [3:0]  alu_op_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        instret_o
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        trap_o
`endif
);

    ctrl_state_t state_reg;
    ctrl_state_t state_next;

    inst_class_t dec_class;
    cs_inst_type dec_inst_type;
    logic [3:0]  dec_alu_op;
    logic        dec_illegal;

    ctrl_decode u_decode (
        .inst       (inst_i),
        .inst_class (dec_class),
        .inst_type  (dec_inst_type),
        .alu_op     (dec_alu_op),
        .illegal    (dec_illegal)
    );

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH:  if (mem_ready_i) state_next = ST_DECODE;
            ST_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (dec_illegal) state_next = ST_TRAP;
                else             state_next = ST_EXEC;
`else
                state_next = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                case (dec_class)
                    CLASS_LOAD, CLASS_STORE:                   state_next = ST_MEM;
                    CLASS_OP, CLASS_OP_IMM, CLASS_LUI, CLASS_AUIPC: state_next = ST_WB;
                    default:                                   state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready_i) begin
                    state_next = (dec_class == CLASS_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:     state_next = ST_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP:   state_next = ST_TRAP;
`endif
            default:   state_next = ST_IDLE;
        endcase
    end

    // Per-state control outputs; anything not driven in a state stays 0.
    always_comb begin
        inst_type_o    = INST_TYPE_R;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_src_o       = PC_SRC_PLUS4;
        alu_a_sel_o    = ALU_A_RS1;
        alu_b_sel_o    = ALU_B_RS2;
        alu_op_o       = 4'b0000;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        rf_we_o        = 1'b0;
        wb_sel_o       = WB_SEL_ALU;
        instret_o      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap_o         = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                // Optional PC initialisation pulse on the way out of reset.
                if (!rst_i) pc_we_o = RST_PC_WE;
            end
            ST_FETCH: begin
                mem_req_o = 1'b1;
                ir_we_o   = mem_ready_i;
            end
            ST_DECODE: begin
                inst_type_o = dec_inst_type;
            end
            ST_EXEC: begin
                inst_type_o = dec_inst_type;
                alu_op_o    = dec_alu_op;
                case (dec_class)
                    CLASS_BRANCH: begin
                        pc_we_o   = 1'b1;
                        pc_src_o  = br_taken_i ? PC_SRC_TARGET : PC_SRC_PLUS4;
                        instret_o = 1'b1;
                    end
                    CLASS_JAL: begin
                        rf_we_o   = 1'b1;
                        wb_sel_o  = WB_SEL_PC4;
                        pc_we_o   = 1'b1;
                        pc_src_o  = PC_SRC_TARGET;
                        instret_o = 1'b1;
                    end
                    CLASS_JALR: begin
                        alu_b_sel_o = ALU_B_IMM;
                        rf_we_o     = 1'b1;
                        wb_sel_o    = WB_SEL_PC4;
                        pc_we_o     = 1'b1;
                        pc_src_o    = PC_SRC_ALU;
                        instret_o   = 1'b1;
                    end
                    CLASS_LOAD, CLASS_STORE, CLASS_OP_IMM: begin
                        alu_b_sel_o = ALU_B_IMM;
                    end
                    CLASS_OP: begin
                        alu_b_sel_o = ALU_B_RS2;
                    end
                    CLASS_LUI: begin
                        alu_a_sel_o = ALU_A_ZERO;
                        alu_b_sel_o = ALU_B_IMM;
                    end
                    CLASS_AUIPC: begin
                        alu_a_sel_o = ALU_A_PC;
                        alu_b_sel_o = ALU_B_IMM;
                    end
                    default: begin
                        // FENCE, and illegal encodings when not trapping: a NOP.
                        pc_we_o   = 1'b1;
                        instret_o = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                inst_type_o    = dec_inst_type;
                alu_op_o       = dec_alu_op;
                alu_b_sel_o    = ALU_B_IMM;
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = (dec_class == CLASS_STORE);
                if (mem_ready_i && dec_class == CLASS_STORE) begin
                    pc_we_o   = 1'b1;
                    instret_o = 1'b1;
                end
            end
            ST_WB: begin
                inst_type_o = dec_inst_type;
                rf_we_o     = 1'b1;
                wb_sel_o    = (dec_class == CLASS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
                pc_we_o     = 1'b1;
                instret_o   = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                trap_o = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
